poly_tone_sequencer: RTL and testbench

//  Programmable multi-voice square-wave music sequencer; successor to the single-song music processor.

---
 rtl/alive_pkg.sv | 32 +++
 rtl/tone_voice.sv | 42 ++++
 rtl/poly_tone_sequencer.sv | 167 ++++++++++++++++
 tb/tb_poly_tone_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alive_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alive_pkg
//  Description : Shared FSM state encodings and song-table field helpers for
//                poly_tone_sequencer and its voice sub-module.
//  Revision    : 1.0  initial release
// ============================================================================
package alive_pkg;

    // Sequencer FSM states (2-bit encoding)
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_PLAY = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // Width of one song-table entry: {dur, pitch[NV-1], ..., pitch[0]}
    function automatic int entry_width(input int nv, input int pw, input int dw);
        return dw + nv * pw;
    endfunction

    // Bit position of the duration field inside an entry
    function automatic int dur_lsb(input int nv, input int pw);
        return nv * pw;
    endfunction

    // Bit position of pitch field v inside an entry
    function automatic int pitch_lsb(input int v, input int pw);
        return v * pw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_voice.sv
`default_nettype none
// ============================================================================
//  Module      : tone_voice
//  Description : One square-wave voice. A half-period counter toggles the
//                output each time it reaches pitch-1; pitch 0 is a rest.
//  Revision    : 1.0  initial release
// ============================================================================
module tone_voice
    import alive_pkg::*;
#(
    parameter int PITCH_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [PITCH_W-1:0] pitch,
    output logic               out
);

    logic [PITCH_W-1:0] r_cnt;
    logic               r_out;

    // Half-period counter and toggle flop; clear or rest forces silence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (clear || (pitch == '0)) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (r_cnt >= (pitch - PITCH_W'(1))) begin
            r_cnt <= '0;
            r_out <= ~r_out;
        end else begin
            r_cnt <= r_cnt + PITCH_W'(1);
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: rtl/poly_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : poly_tone_sequencer
//  Description : Multi-voice square-wave music sequencer with a writable song
//                table, ms prescaler, duration counter, play-once or looping
//                playback, mixed speaker bit and 8-bit LED status.
//  Build option: POLY_TONE_ARTIC_EN - silence each note during its final ms.
//  Revision    : 1.0  initial release
// ============================================================================
module poly_tone_sequencer
    import alive_pkg::*;
#(
    parameter int NUM_VOICES = 2,
    parameter int STEPS      = 16,
    parameter int PITCH_W    = 16,
    parameter int DUR_W      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [15:0]                         ticks_per_milli,
    input  logic                                start,
    input  logic                                stop,
    input  logic                                loop_en,
    input  logic                                wr_en,
    input  logic [$clog2(STEPS)-1:0]            wr_addr,
    input  logic [DUR_W+NUM_VOICES*PITCH_W-1:0] wr_data,
    output logic [NUM_VOICES-1:0]               voice_out,
    output logic                                sound,
    output logic                                busy,
    output logic [7:0]                          led
);

    localparam int ADDR_W    = $clog2(STEPS);
    localparam int ENTRY_W   = entry_width(NUM_VOICES, PITCH_W, DUR_W);
    localparam int DUR_LSB   = dur_lsb(NUM_VOICES, PITCH_W);
    localparam int PITCHES_W = NUM_VOICES * PITCH_W;
    localparam logic [ADDR_W-1:0] c_LAST_STEP = ADDR_W'(STEPS - 1);

    logic [ENTRY_W-1:0]   r_table [STEPS];
    logic [1:0]           r_state;
    logic [ADDR_W-1:0]    r_step_idx;
    logic [15:0]          r_presc;
    logic [DUR_W-1:0]     r_remaining;
    logic [PITCHES_W-1:0] r_pitches;

    logic [ENTRY_W-1:0]   w_entry;
    logic [DUR_W-1:0]     w_load_dur;
    logic [15:0]          w_tpm_max;
    logic                 w_ms_tick;
    logic                 w_last_ms;
    logic                 w_artic_mute;
    logic                 w_voice_clear;
    logic [NUM_VOICES-1:0] w_voice;

    assign w_entry    = r_table[r_step_idx];
    assign w_load_dur = w_entry[DUR_LSB +: DUR_W];

    // A programmed rate of 0 behaves as 1 so the prescaler always wraps
    assign w_tpm_max = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
    // >= so a mid-note rate decrease still wraps instead of running to overflow
    assign w_ms_tick = (r_state == c_ST_PLAY) && (r_presc >= (w_tpm_max - 16'd1));
    assign w_last_ms = w_ms_tick && (r_remaining <= DUR_W'(1));

`ifdef POLY_TONE_ARTIC_EN
    // Mute one cycle early so the registered voice is already 0 for the final ms
    assign w_artic_mute = (r_state == c_ST_PLAY) &&
                          ((r_remaining == DUR_W'(1)) ||
                           ((r_remaining == DUR_W'(2)) && w_ms_tick));
`else
    assign w_artic_mute = 1'b0;
`endif

    // Voices only run in PLAY; LOAD clears them so every note starts phase-aligned
    assign w_voice_clear = stop || (r_state != c_ST_PLAY) || w_artic_mute;

    // Song table: synchronous writes in any state, contents not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Sequencer FSM, step index, prescaler and duration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_step_idx  <= '0;
            r_presc     <= '0;
            r_remaining <= '0;
            r_pitches   <= '0;
        end else if (stop) begin
            r_state     <= c_ST_IDLE;
            r_step_idx  <= '0;
            r_presc     <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state    <= c_ST_LOAD;
                        r_step_idx <= '0;
                    end
                end
                c_ST_LOAD: begin
                    r_pitches   <= w_entry[PITCHES_W-1:0];
                    r_remaining <= w_load_dur;
                    r_presc     <= '0;
                    if (w_load_dur == '0) begin
                        // A zero-length step ends the song; an empty song never loops
                        if ((r_step_idx == '0) || !loop_en) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_state    <= c_ST_LOAD;
                            r_step_idx <= '0;
                        end
                    end else begin
                        r_state <= c_ST_PLAY;
                    end
                end
                c_ST_PLAY: begin
                    if (w_ms_tick) begin
                        r_presc     <= '0;
                        r_remaining <= r_remaining - DUR_W'(1);
                        if (w_last_ms) begin
                            if (r_step_idx == c_LAST_STEP) begin
                                if (loop_en) begin
                                    r_state    <= c_ST_LOAD;
                                    r_step_idx <= '0;
                                end else begin
                                    r_state <= c_ST_DONE;
                                end
                            end else begin
                                r_state    <= c_ST_LOAD;
                                r_step_idx <= r_step_idx + ADDR_W'(1);
                            end
                        end
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // One tone generator per voice, pitch taken from the latched entry
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        tone_voice #(
            .PITCH_W (PITCH_W)
        ) u_voice (
            .clk   (clk),
            .rst   (rst),
            .clear (w_voice_clear),
            .pitch (r_pitches[pitch_lsb(gi, PITCH_W) +: PITCH_W]),
            .out   (w_voice[gi])
        );
    end

    assign voice_out = w_voice;
    assign sound     = |w_voice;
    assign busy      = (r_state == c_ST_LOAD) || (r_state == c_ST_PLAY);
    assign led       = {busy, (r_state == c_ST_DONE), 6'(r_step_idx)};

endmodule
`default_nettype wire

// File: tb/tb_poly_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_tone_sequencer
//  Description : Self-checking bench for poly_tone_sequencer (default
//                parameters, 2 voices, 16 steps).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_poly_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ticks_per_milli = 16'd4;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [39:0] wr_data = '0;
    logic [1:0]  voice_out;
    logic        sound;
    logic        busy;
    logic [7:0]  led;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] voice;
        logic [7:0] led;
    } exp_t;

    exp_t exp_q[$];

    poly_tone_sequencer #(
        .NUM_VOICES (2),
        .STEPS      (16),
        .PITCH_W    (16),
        .DUR_W      (8)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .start           (start),
        .stop            (stop),
        .loop_en         (loop_en),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .voice_out       (voice_out),
        .sound           (sound),
        .busy            (busy),
        .led             (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_step(input int addr, input int dur, input int p0, input int p1);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = {8'(dur), 16'(p1), 16'(p0)};
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({voice_out, sound, busy, led} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got voice=%b sound=%b busy=%b led=%h, want all 0",
                     voice_out, sound, busy, led);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // tpm=4, step0 {dur=3, p0=2, p1=0}, step1 dur=0 -> 12 PLAY cycles then DONE
    task automatic run_basic_note(input string tag);
        exp_t e;
        logic v0;
        // c=0 LOAD, c=1..12 PLAY, c=13 LOAD of empty step 1, c=14 DONE
        for (int c = 0; c <= 14; c++) begin
            v0 = 1'b0;
            if (c >= 1 && c <= 12) begin
                v0 = 1'(((c - 1) / 2) % 2);
`ifdef POLY_TONE_ARTIC_EN
                if (c > 8) v0 = 1'b0;
`endif
            end
            e.voice = {1'b0, v0};
            e.led   = (c <= 12) ? 8'h80 : ((c == 13) ? 8'h81 : 8'h41);
            exp_q.push_back(e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; exp_q.size() > 0; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (voice_out !== e.voice || led !== e.led || sound !== (|e.voice)) begin
                errors++;
                $display("FAIL %s c=%0d: got voice=%b sound=%b led=%h, want voice=%b sound=%b led=%h",
                         tag, c, voice_out, sound, led, e.voice, |e.voice, e.led);
            end
            tick();
        end
    endtask

    task automatic test_basic_note();
        ticks_per_milli = 16'd4;
        loop_en = 1'b0;
        write_step(0, 3, 2, 0);
        write_step(1, 0, 0, 0);
        run_basic_note("basic_note");
    endtask

    task automatic test_back_to_back();
        run_basic_note("restart_from_done");
    endtask

    task automatic test_reset_mid_play();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: got busy=%b, want 1", busy);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({voice_out, sound, busy, led} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: got voice=%b sound=%b busy=%b led=%h, want all 0",
                     voice_out, sound, busy, led);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_idle: got led=%h, want 00", led);
        end
    endtask

    // tpm=0 behaves as 1: a dur=2 note lasts exactly 2 PLAY cycles
    task automatic test_zero_tpm();
        exp_t e;
        ticks_per_milli = 16'd0;
        write_step(0, 2, 0, 0);
        write_step(1, 0, 0, 0);
        for (int c = 0; c <= 5; c++) begin
            e.voice = 2'b00;
            e.led   = (c <= 2) ? 8'h80 : ((c == 3) ? 8'h81 : 8'h41);
            exp_q.push_back(e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; exp_q.size() > 0; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e.led || voice_out !== e.voice) begin
                errors++;
                $display("FAIL zero_tpm c=%0d: got led=%h voice=%b, want led=%h voice=%b",
                         c, led, voice_out, e.led, e.voice);
            end
            tick();
        end
    endtask

    // All 16 steps dur=1 at tpm=1: 2 cycles per step, wraps 15->0 while looping
    task automatic test_loop_wrap();
        exp_t e;
        ticks_per_milli = 16'd1;
        for (int s = 0; s < 16; s++) write_step(s, 1, 0, 0);
        loop_en = 1'b1;
        for (int c = 0; c <= 65; c++) begin
            e.voice = 2'b00;
            e.led   = (c <= 63) ? {2'b10, 6'((c / 2) % 16)} : 8'h4F;
            exp_q.push_back(e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; exp_q.size() > 0; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e.led || busy !== e.led[7]) begin
                errors++;
                $display("FAIL loop_wrap c=%0d: got led=%h busy=%b, want led=%h busy=%b",
                         c, led, busy, e.led, e.led[7]);
            end
            if (c == 40) loop_en = 1'b0;
            tick();
        end
    endtask

    // stop and start together during PLAY: IDLE, step 0, silent next cycle
    task automatic test_stop_start();
        ticks_per_milli = 16'd1;
        write_step(0, 200, 1, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (voice_out !== 2'b11 || sound !== 1'b1) begin
            errors++;
            $display("FAIL pre_stop_sound: got voice=%b sound=%b, want voice=11 sound=1",
                     voice_out, sound);
        end
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (led !== 8'h00 || sound !== 1'b0 || busy !== 1'b0 || voice_out !== 2'b00) begin
                errors++;
                $display("FAIL stop_start i=%0d: got led=%h sound=%b busy=%b voice=%b, want 00 0 0 00",
                         i, led, sound, busy, voice_out);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_note();
        test_back_to_back();
        test_reset_mid_play();
        test_zero_tpm();
        test_loop_wrap();
        test_stop_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
